// File: rtl/if_hazard_controller.sv
// IF-stage hazard controller: sequences PC write-enable, branch-target select,
// IF/ID write/flush and an ID/EX bubble from load-use hazards, taken branches
// and a slow instruction memory. Also keeps saturating stall/flush counters.
module if_hazard_controller #(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_rt,
  input  logic [REG_ADDR_W-1:0] if_id_rs,
  input  logic [REG_ADDR_W-1:0] if_id_rt,
  input  logic                  branch_taken,
  input  logic                  imem_ready,
  output logic                  pc_write,
  output logic                  pc_src,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count,
  output logic [1:0]            state
);

  localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_INIT = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2,
    UNUSED   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              stall_inc;
  logic              flush_inc;
  logic              hazard;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // A load in EX whose destination (not $zero) is read by the instruction in ID.
  assign hazard = id_ex_mem_read & (id_ex_rt != '0) &
                  ((id_ex_rt == if_id_rs) | (id_ex_rt == if_id_rt));

  assign state = state_q;

  // Next-state and control outputs: branch beats hazard beats memory wait.
  always_comb begin
    pc_write     = 1'b1;
    pc_src       = 1'b0;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    if (branch_taken) begin
      // Redirect to the branch target; any outstanding fetch is abandoned.
      pc_src       = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      flush_inc    = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        fcnt_d  = FCNT_INIT;
      end else begin
        state_d = RUN;
        fcnt_d  = '0;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (hazard) begin
            // One stall cycle: the bubble removes the load from EX next cycle.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            stall_inc    = 1'b1;
          end else if (!imem_ready) begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
            state_d     = MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          // IF/ID holds a NOP here, so a hazard cannot exist against it.
          if (!imem_ready) begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        FLUSH: begin
          if_id_flush = 1'b1;
          pc_write    = imem_ready;
          if (fcnt_q <= FCNT_ONE) begin
            fcnt_d  = '0;
            state_d = RUN;
          end else begin
            fcnt_d = fcnt_q - FCNT_ONE;
          end
        end
        default: state_d = RUN;
      endcase
    end
    if (!reset_n) begin
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end
  end

  // FSM state and flush-cycle counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Saturating event counters for the log dumps.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_inc) stall_count <= sat_inc(stall_count);
      if (flush_inc) flush_count <= sat_inc(flush_count);
    end
  end

endmodule

// File: tb/tb_if_hazard_controller.sv
// Bench for if_hazard_controller: two instances (FLUSH_CYCLES=2/CNT_W=2 and
// FLUSH_CYCLES=1/CNT_W=16) share stimulus; a rule-level model predicts outputs.
module tb_if_hazard_controller;
  localparam int RW = 5;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          id_ex_mem_read = 1'b0;
  logic [RW-1:0] id_ex_rt = '0;
  logic [RW-1:0] if_id_rs = '0;
  logic [RW-1:0] if_id_rt = '0;
  logic          branch_taken = 1'b0;
  logic          imem_ready = 1'b1;

  // bit 0 = instance a, bit 1 = instance b
  logic [1:0]  pc_write, pc_src, if_id_write, if_id_flush, id_ex_bubble;
  logic [1:0]  st_a, st_b;
  logic [1:0]  sc_a, fc_a;
  logic [15:0] sc_b, fc_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  if_hazard_controller #(.REG_ADDR_W(RW), .FLUSH_CYCLES(2), .CNT_W(2)) u_a (
    .clock(clock), .reset_n(reset_n), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_rt(id_ex_rt), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .branch_taken(branch_taken), .imem_ready(imem_ready),
    .pc_write(pc_write[0]), .pc_src(pc_src[0]), .if_id_write(if_id_write[0]),
    .if_id_flush(if_id_flush[0]), .id_ex_bubble(id_ex_bubble[0]),
    .stall_count(sc_a), .flush_count(fc_a), .state(st_a));

  if_hazard_controller #(.REG_ADDR_W(RW), .FLUSH_CYCLES(1), .CNT_W(16)) u_b (
    .clock(clock), .reset_n(reset_n), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_rt(id_ex_rt), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .branch_taken(branch_taken), .imem_ready(imem_ready),
    .pc_write(pc_write[1]), .pc_src(pc_src[1]), .if_id_write(if_id_write[1]),
    .if_id_flush(if_id_flush[1]), .id_ex_bubble(id_ex_bubble[1]),
    .stall_count(sc_b), .flush_count(fc_b), .state(st_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int fc(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int cmax(input int i);
    return (i == 0) ? 3 : 65535;
  endfunction

  function automatic int sat(input int v, input int i);
    return (v > cmax(i)) ? cmax(i) : v;
  endfunction

  function automatic bit hazard_now();
    return id_ex_mem_read && (id_ex_rt != 0) &&
           (id_ex_rt == if_id_rs || id_ex_rt == if_id_rt);
  endfunction

  // Model: mode 0=running, 1=flushing, 2=waiting for memory; left = flush cycles still owed.
  int m_mode [2] = '{0, 0};
  int m_left [2] = '{0, 0};
  int m_stall[2] = '{0, 0};
  int m_flush[2] = '{0, 0};
  int n_mode [2] = '{0, 0};
  int n_left [2] = '{0, 0};
  int n_stall[2] = '{0, 0};
  int n_flush[2] = '{0, 0};

  bit          e_pw, e_src, e_iw, e_fl, e_bub;
  logic [15:0] a_sc, a_fc;
  logic [1:0]  a_st;

  // Compare process: predicts this cycle's outputs and next model state.
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      e_pw = 1'b1; e_src = 1'b0; e_iw = 1'b1; e_fl = 1'b0; e_bub = 1'b0;
      n_mode[i]  = m_mode[i];
      n_left[i]  = m_left[i];
      n_stall[i] = m_stall[i];
      n_flush[i] = m_flush[i];
      if (!reset_n) begin
        e_pw = 1'b0; e_iw = 1'b0; e_fl = 1'b1; e_bub = 1'b1;
        n_mode[i] = 0; n_left[i] = 0; n_stall[i] = 0; n_flush[i] = 0;
      end else if (branch_taken) begin
        e_src = 1'b1; e_fl = 1'b1; e_bub = 1'b1;
        n_flush[i] = sat(m_flush[i] + 1, i);
        n_left[i]  = fc(i) - 1;
        n_mode[i]  = (fc(i) > 1) ? 1 : 0;
      end else if (m_mode[i] == 0 && hazard_now()) begin
        e_pw = 1'b0; e_iw = 1'b0; e_bub = 1'b1;
        n_stall[i] = sat(m_stall[i] + 1, i);
      end else if (m_mode[i] == 0 && !imem_ready) begin
        e_pw = 1'b0; e_fl = 1'b1;
        n_mode[i] = 2;
      end else if (m_mode[i] == 2) begin
        if (!imem_ready) begin
          e_pw = 1'b0; e_fl = 1'b1;
        end else begin
          n_mode[i] = 0;
        end
      end else if (m_mode[i] == 1) begin
        e_fl = 1'b1;
        e_pw = imem_ready;
        n_left[i] = m_left[i] - 1;
        if (n_left[i] <= 0) begin
          n_left[i] = 0;
          n_mode[i] = 0;
        end
      end
      a_st = (i == 0) ? st_a : st_b;
      a_sc = (i == 0) ? {14'd0, sc_a} : sc_b;
      a_fc = (i == 0) ? {14'd0, fc_a} : fc_b;
      chk($sformatf("pc_write[%0d]", i), pc_write[i], e_pw);
      chk($sformatf("pc_src[%0d]", i), pc_src[i], e_src);
      chk($sformatf("if_id_write[%0d]", i), if_id_write[i], e_iw);
      chk($sformatf("if_id_flush[%0d]", i), if_id_flush[i], e_fl);
      chk($sformatf("id_ex_bubble[%0d]", i), id_ex_bubble[i], e_bub);
      chk($sformatf("state[%0d]", i), a_st, m_mode[i]);
      chk($sformatf("stall_count[%0d]", i), a_sc, m_stall[i]);
      chk($sformatf("flush_count[%0d]", i), a_fc, m_flush[i]);
    end
  end

  // Model state register, reset asynchronously like the design.
  always @(posedge clock or negedge reset_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        m_mode[i] = 0; m_left[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
      end else begin
        m_mode[i] = n_mode[i]; m_left[i] = n_left[i];
        m_stall[i] = n_stall[i]; m_flush[i] = n_flush[i];
      end
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // reset held for two cycles
    repeat (2) @(posedge clock);
    #2;
    chk("rst_pc_write", pc_write, 2'b00);
    chk("rst_if_id_flush", if_id_flush, 2'b11);
    chk("rst_id_ex_bubble", id_ex_bubble, 2'b11);
    next_cycle();
    reset_n = 1'b1;
    #1;
    chk("rst_state_a", st_a, 0);
    chk("rst_stall_a", sc_a, 0);
    chk("rst_flush_b", fc_b, 0);

    // load-use hazard: exactly one stall cycle
    next_cycle();
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd8; if_id_rs = 5'd8;
    #1;
    chk("lu_pc_write", pc_write, 2'b00);
    chk("lu_if_id_write", if_id_write, 2'b00);
    chk("lu_bubble", id_ex_bubble, 2'b11);
    next_cycle();
    id_ex_mem_read = 1'b0;
    #1;
    chk("lu_after_pc_write", pc_write, 2'b11);
    chk("lu_stall_a", sc_a, 1);
    chk("lu_stall_b", sc_b, 1);
    next_cycle();
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0;
    #1;
    chk("r0_pc_write", pc_write, 2'b11);
    chk("r0_bubble", id_ex_bubble, 2'b00);
    next_cycle();
    id_ex_mem_read = 1'b0;
    #1;
    chk("r0_stall_a", sc_a, 1);

    // taken branch
    next_cycle();
    branch_taken = 1'b1;
    #1;
    chk("br_pc_src", pc_src, 2'b11);
    chk("br_flush", if_id_flush, 2'b11);
    next_cycle();
    branch_taken = 1'b0;
    #1;
    chk("br_state_a", st_a, 1);
    chk("br_state_b", st_b, 0);
    chk("br2_pc_src", pc_src, 2'b00);
    chk("br2_flush", if_id_flush, 2'b01);
    next_cycle();
    #1;
    chk("br3_state_a", st_a, 0);
    chk("br3_flush", if_id_flush, 2'b00);
    chk("br_count_a", fc_a, 1);
    chk("br_count_b", fc_b, 1);

    // branch and hazard together: branch wins
    next_cycle();
    branch_taken = 1'b1; id_ex_mem_read = 1'b1; id_ex_rt = 5'd8; if_id_rs = 5'd8;
    #1;
    chk("bh_pc_src", pc_src, 2'b11);
    chk("bh_pc_write", pc_write, 2'b11);
    chk("bh_if_id_write", if_id_write, 2'b11);
    next_cycle();
    branch_taken = 1'b0; id_ex_mem_read = 1'b0;
    #1;
    chk("bh_stall_a", sc_a, 1);
    chk("bh_flush_a", fc_a, 2);
    chk("bh_flush_b", fc_b, 2);
    next_cycle();

    // slow instruction memory
    next_cycle();
    imem_ready = 1'b0;
    #1;
    chk("mw_pc_write0", pc_write, 2'b00);
    chk("mw_flush0", if_id_flush, 2'b11);
    for (int k = 1; k < 3; k++) begin
      next_cycle();
      #1;
      chk("mw_pc_write", pc_write, 2'b00);
      chk("mw_flush", if_id_flush, 2'b11);
      chk("mw_state_a", st_a, 2);
      chk("mw_state_b", st_b, 2);
    end
    next_cycle();
    imem_ready = 1'b1;
    #1;
    chk("mw_ready_pc_write", pc_write, 2'b11);
    next_cycle();
    #1;
    chk("mw_done_state_a", st_a, 0);

    // asynchronous reset in the middle of a memory wait
    next_cycle();
    imem_ready = 1'b0;
    next_cycle();
    chk("ar_pre_state_a", st_a, 2);
    #1;
    reset_n = 1'b0;
    #1;
    chk("ar_state_a", st_a, 0);
    chk("ar_state_b", st_b, 0);
    chk("ar_flush_a", fc_a, 0);
    chk("ar_pc_write", pc_write, 2'b00);
    reset_n = 1'b1;
    imem_ready = 1'b1;

    // separated stalls saturate a 2-bit counter
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      id_ex_mem_read = 1'b1; id_ex_rt = 5'd5; if_id_rt = 5'd5; if_id_rs = 5'd0;
      next_cycle();
      id_ex_mem_read = 1'b0;
      #1;
      chk("sat_stall_a", sc_a, (k < 3) ? k + 1 : 3);
      chk("sat_stall_b", sc_b, k + 1);
    end

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      next_cycle();
      id_ex_mem_read = 1'($urandom_range(0, 1));
      id_ex_rt       = RW'($urandom_range(0, 3));
      if_id_rs       = RW'($urandom_range(0, 3));
      if_id_rt       = RW'($urandom_range(0, 3));
      branch_taken   = ($urandom_range(0, 9) == 0);
      imem_ready     = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) begin
        #1 reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
    end

    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
